// File: rtl/jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : jk_bank_sequencer
//  Description : Drives a bank of WIDTH external JK flip-flops through their
//                J/K inputs, using the bank's Q outputs as feedback.
//                Commands arrive on a valid/ready interface:
//                  0 NOP, 1 CLEAR, 2 PRESET, 3 LOAD, 4 COUNT_UP,
//                  5 COUNT_DOWN, 6 TOGGLE, 7 reserved (NOP).
//                The bank is clocked on the falling edge. A J/K pattern
//                registered here on a rising edge therefore shows up on q_fb
//                at the next rising edge.
//  Optional    : define JK_STEP_LIMIT_EN to add a step counter. A count that
//                applies 2**WIDTH steps without reaching its target is then
//                stopped and err is set. When the macro is undefined, err is
//                tied low.
//  Ports       : clk        rising-edge clock
//                rst_n      asynchronous active-low reset
//                cmd_valid  command request
//                cmd_ready  high only in IDLE
//                cmd_op     command opcode (3 bits)
//                cmd_data   load value / count target, captured on accept
//                abort      stops an active count
//                q_fb       Q outputs of the JK bank
//                j, k       J/K drive to the bank (registered)
//                busy       state is not IDLE
//                done       one-cycle completion pulse
//                tc         one-cycle pulse on a wrap step
//                aborted    count ended by abort (sticky until next accept)
//                err        step-limit error (sticky until next accept)
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             tc,
    output logic             aborted,
    output logic             err
);

    localparam logic [2:0] c_op_clear      = 3'd1;
    localparam logic [2:0] c_op_preset     = 3'd2;
    localparam logic [2:0] c_op_load       = 3'd3;
    localparam logic [2:0] c_op_count_up   = 3'd4;
    localparam logic [2:0] c_op_count_down = 3'd5;
    localparam logic [2:0] c_op_toggle     = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [WIDTH-1:0] r_target,   w_target_nxt;
    logic [WIDTH-1:0] r_j,        w_j_nxt;
    logic [WIDTH-1:0] r_k,        w_k_nxt;
    logic             r_dir_down, w_dir_down_nxt;
    logic             r_tc,       w_tc_nxt;
    logic             r_aborted,  w_aborted_nxt;
    logic             w_accept;
    logic [WIDTH-1:0] w_up_mask;
    logic [WIDTH-1:0] w_dn_mask;

`ifdef JK_STEP_LIMIT_EN
    localparam logic [WIDTH:0] c_step_limit = {1'b1, {WIDTH{1'b0}}};
    logic [WIDTH:0]   r_step_cnt, w_step_cnt_nxt;
    logic             r_err,      w_err_nxt;
`endif

    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign j         = r_j;
    assign k         = r_k;
    assign tc        = r_tc;
    assign aborted   = r_aborted;

    // A bit flips on an up-count step when every lower bit is one, and on a
    // down-count step when every lower bit is zero. Bit 0 always flips.
    always_comb begin
        logic [WIDTH-1:0] low;
        w_up_mask = '0;
        w_dn_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            low          = (WIDTH'(1) << i) - WIDTH'(1);
            w_up_mask[i] = ((q_fb & low) == low);
            w_dn_mask[i] = ((q_fb & low) == '0);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_dir_down_nxt = r_dir_down;
        w_aborted_nxt  = r_aborted;
        w_j_nxt        = '0;
        w_k_nxt        = '0;
        w_tc_nxt       = 1'b0;
`ifdef JK_STEP_LIMIT_EN
        w_step_cnt_nxt = r_step_cnt;
        w_err_nxt      = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_target_nxt  = cmd_data;
                    w_aborted_nxt = 1'b0;
`ifdef JK_STEP_LIMIT_EN
                    w_step_cnt_nxt = '0;
                    w_err_nxt      = 1'b0;
`endif
                    // Single-shot patterns are registered on the accept edge
                    // so they are applied during the APPLY cycle itself.
                    w_state_nxt = S_APPLY;
                    case (cmd_op)
                        c_op_clear:      w_k_nxt = '1;
                        c_op_preset:     w_j_nxt = '1;
                        c_op_load: begin
                            w_j_nxt = cmd_data;
                            w_k_nxt = ~cmd_data;
                        end
                        c_op_toggle: begin
                            w_j_nxt = '1;
                            w_k_nxt = '1;
                        end
                        c_op_count_up: begin
                            w_state_nxt    = S_COUNT;
                            w_dir_down_nxt = 1'b0;
                        end
                        c_op_count_down: begin
                            w_state_nxt    = S_COUNT;
                            w_dir_down_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_APPLY: begin
                w_state_nxt = S_DONE;
            end
            S_COUNT: begin
                if (q_fb == r_target) begin
                    w_state_nxt = S_DONE;
                end else if (abort) begin
                    w_state_nxt   = S_DONE;
                    w_aborted_nxt = 1'b1;
                end
`ifdef JK_STEP_LIMIT_EN
                else if (r_step_cnt == c_step_limit) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end
`endif
                else begin
                    w_j_nxt  = r_dir_down ? w_dn_mask : w_up_mask;
                    w_k_nxt  = r_dir_down ? w_dn_mask : w_up_mask;
                    w_tc_nxt = r_dir_down ? (q_fb == '0) : (q_fb == '1);
`ifdef JK_STEP_LIMIT_EN
                    w_step_cnt_nxt = r_step_cnt + 1'b1;
`endif
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_target   <= '0;
            r_dir_down <= 1'b0;
            r_j        <= '0;
            r_k        <= '0;
            r_tc       <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_dir_down <= w_dir_down_nxt;
            r_j        <= w_j_nxt;
            r_k        <= w_k_nxt;
            r_tc       <= w_tc_nxt;
            r_aborted  <= w_aborted_nxt;
        end
    end

`ifdef JK_STEP_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_step_cnt <= w_step_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_bank_sequencer
//  Description : Self-checking bench for jk_bank_sequencer with a behavioural
//                JK bank on the falling edge and a value-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_sequencer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             abort;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic             tc;
    logic             aborted;
    logic             err;

    logic [WIDTH-1:0] bank_q = 4'h0;
    logic             stuck  = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    jk_bank_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .abort     (abort),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .tc        (tc),
        .aborted   (aborted),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External JK bank: falling-edge flip-flops, no reset.
    always @(negedge clk) begin
        for (int b = 0; b < WIDTH; b++) begin
            case ({j[b], k[b]})
                2'b10:   bank_q[b] <= 1'b1;
                2'b01:   bank_q[b] <= 1'b0;
                2'b11:   bank_q[b] <= ~bank_q[b];
                default: bank_q[b] <= bank_q[b];
            endcase
        end
    end
    assign q_fb = stuck ? '0 : bank_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one command and check every cycle against the value-level model.
    // Caller is positioned 1 time unit after a rising edge.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] data, input int ab_after,
                           input bit spam, output logic [3:0] q_end, output int lat,
                           output int tcs, output logic ab_seen);
        logic [3:0] q0, cur, nxt, pj, pk, exp_q, ej;
        logic       etc;
        int         nsteps, nend, done_c;
        bit         is_cnt, down, by_abort;

        for (int w = 0; w < 20 && cmd_ready !== 1'b1; w++) begin
            @(posedge clk); #1;
        end
        chk("ready_wait", {31'd0, cmd_ready}, 32'd1);

        q0        = q_fb;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        is_cnt = (op == 3'd4) || (op == 3'd5);
        down   = (op == 3'd5);
        cur    = q0;
        nsteps = 0;
        while (cur != data && nsteps < 16) begin
            cur = down ? cur - 4'd1 : cur + 4'd1;
            nsteps++;
        end
        by_abort = is_cnt && ab_after >= 0 && ab_after < nsteps;
        nend     = !is_cnt ? 0 : (by_abort ? ab_after : nsteps);
        done_c   = is_cnt ? nend + 1 : 1;

        pj = 4'h0; pk = 4'h0; exp_q = q0;
        case (op)
            3'd1: begin pk = 4'hF; exp_q = 4'h0; end
            3'd2: begin pj = 4'hF; exp_q = 4'hF; end
            3'd3: begin pj = data; pk = ~data; exp_q = data; end
            3'd6: begin pj = 4'hF; pk = 4'hF; exp_q = ~q0; end
            3'd4: exp_q = q0 + 4'(nend);
            3'd5: exp_q = q0 - 4'(nend);
            default: ;
        endcase

        tcs = 0;
        lat = -1;
        for (int c = 0; c <= done_c; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            ej  = 4'h0;
            etc = 1'b0;
            if (!is_cnt) begin
                if (c == 0) ej = pj;
                chk("k_pattern", {28'd0, k}, {28'd0, (c == 0) ? pk : 4'h0});
            end else if (c >= 1 && c <= nend) begin
                cur = down ? q0 - 4'(c - 1) : q0 + 4'(c - 1);
                nxt = down ? cur - 4'd1 : cur + 4'd1;
                ej  = cur ^ nxt;
                etc = down ? (cur == 4'h0) : (cur == 4'hF);
                chk("k_step", {28'd0, k}, {28'd0, ej});
            end else begin
                chk("k_idle", {28'd0, k}, 32'd0);
            end
            chk("j", {28'd0, j}, {28'd0, ej});
            chk("tc", {31'd0, tc}, {31'd0, etc});
            chk("done", {31'd0, done}, {31'd0, c == done_c});
            chk("busy", {31'd0, busy}, 32'd1);
            if (tc === 1'b1) tcs++;
            if (done === 1'b1 && lat < 0) lat = c + 1;
            if (is_cnt && c == ab_after) abort = 1'b1;
            if (spam && c < done_c) begin
                cmd_valid = 1'b1;
                cmd_op    = 3'd3;
                cmd_data  = ~q0;
            end else begin
                cmd_valid = 1'b0;
            end
        end
        abort = 1'b0;
        chk("aborted", {31'd0, aborted}, {31'd0, by_abort});
        chk("err_clear", {31'd0, err}, 32'd0);
        chk("q_final", {28'd0, q_fb}, {28'd0, exp_q});
        ab_seen = aborted;

        @(posedge clk); #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("q_hold", {28'd0, q_fb}, {28'd0, exp_q});
        q_end = q_fb;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] data;
        logic [3:0] pre;
        int         ab_after;
        bit         spam;
        logic [3:0] exp_q;
        int         exp_lat;
        int         exp_tc;
        logic       exp_ab;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [3:0] q_end;
        int         lat, tcs;
        logic       ab_seen;

        vecs[0] = '{3'd3, 4'hA, 4'h0, -1, 1'b0, 4'hA, 2, 0, 1'b0};  // LOAD A
        vecs[1] = '{3'd4, 4'h7, 4'h3, -1, 1'b0, 4'h7, 6, 0, 1'b0};  // up 3->7
        vecs[2] = '{3'd4, 4'h1, 4'hE, -1, 1'b0, 4'h1, 5, 1, 1'b0};  // up 14->1 wrap
        vecs[3] = '{3'd5, 4'h0, 4'h0, -1, 1'b1, 4'h0, 2, 0, 1'b0};  // down 0->0, LOAD ignored
        vecs[4] = '{3'd4, 4'hF, 4'h0,  5, 1'b0, 4'h5, 7, 0, 1'b1};  // abort after 5
        vecs[5] = '{3'd1, 4'h3, 4'h9, -1, 1'b0, 4'h0, 2, 0, 1'b0};  // CLEAR
        vecs[6] = '{3'd2, 4'h0, 4'h0, -1, 1'b1, 4'hF, 2, 0, 1'b0};  // PRESET
        vecs[7] = '{3'd6, 4'h0, 4'h5, -1, 1'b0, 4'hA, 2, 0, 1'b0};  // TOGGLE
        vecs[8] = '{3'd7, 4'hC, 4'h3, -1, 1'b0, 4'h3, 2, 0, 1'b0};  // reserved
        vecs[9] = '{3'd5, 4'hE, 4'h2, -1, 1'b0, 4'hE, 6, 1, 1'b0};  // down 2->14 wrap

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'h0; abort = 1'b0;
        #1;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_jk", {24'd0, j, k}, 32'd0);
        chk("rst_flags", {28'd0, done, tc, aborted, err}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_cmd(3'd3, vecs[i].pre, -1, 1'b0, q_end, lat, tcs, ab_seen);
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].ab_after, vecs[i].spam,
                    q_end, lat, tcs, ab_seen);
            chk($sformatf("vec%0d_q", i), {28'd0, q_end}, {28'd0, vecs[i].exp_q});
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_tc", i), tcs, vecs[i].exp_tc);
            chk($sformatf("vec%0d_ab", i), {31'd0, ab_seen}, {31'd0, vecs[i].exp_ab});
        end

        // Reset in the middle of COUNT_UP 0->15 while Q=5.
        run_cmd(3'd3, 4'h0, -1, 1'b0, q_end, lat, tcs, ab_seen);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("mid_q5", {28'd0, q_fb}, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_jk", {24'd0, j, k}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk); #1;
        chk("mid_rst_qhold", {28'd0, q_fb}, 32'd5);
        @(posedge clk); #1;
        chk("mid_rst_nodone", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_q", {28'd0, q_fb}, 32'd5);
        chk("post_rst_done", {31'd0, done}, 32'd0);

`ifdef JK_STEP_LIMIT_EN
        // Feedback stuck at zero: the count can never reach 15.
        begin
            int dc;
            dc    = -1;
            stuck = 1'b1;
            cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = 4'hF;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            for (int c = 1; c < 30 && dc < 0; c++) begin
                @(posedge clk); #1;
                if (done === 1'b1) dc = c;
            end
            chk("limit_done_cycle", dc, 17);
            chk("limit_err", {31'd0, err}, 32'd1);
            chk("limit_jk", {24'd0, j, k}, 32'd0);
            stuck = 1'b0;
            @(posedge clk); #1;
        end
`endif

        for (int r = 0; r < 40; r++) begin
            logic [2:0] rop;
            logic [3:0] rdata;
            int         rab;
            bit         rspam;
            rop   = 3'($urandom_range(0, 7));
            rdata = 4'($urandom);
            rab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
            rspam = 1'($urandom_range(0, 1));
            run_cmd(rop, rdata, rab, rspam, q_end, lat, tcs, ab_seen);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
Controller that drives a bank of WIDTH external JK flip-flops through their J/K inputs and reads their Q outputs back as feedback. It executes commands from a valid/ready interface: clear, preset, load, toggle, and count up or down to a target. The sequencer updates on the rising edge of CLK. The JK bank updates on the falling edge, so each applied J/K pattern is visible on Q_FB at the next rising edge.

Parameters:
WIDTH, 4, number of JK flip-flops in the bank

Ports:
CLK  in  1  clock; sequencer samples and updates on the rising edge
RST_N  in  1  asynchronous, active-low reset
CMD_VALID  in  1  command request
CMD_READY  out  1  high only in IDLE; a command is accepted on the rising edge where VALID and READY are both 1
CMD_OP  in  3  0 NOP, 1 CLEAR, 2 PRESET, 3 LOAD, 4 COUNT_UP, 5 COUNT_DOWN, 6 TOGGLE, 7 reserved (treated as NOP)
CMD_DATA  in  WIDTH  load value (LOAD) or target value (COUNT_*); captured on accept
ABORT  in  1  stops an active count; ignored outside COUNT
Q_FB  in  WIDTH  Q outputs of the JK bank
J  out  WIDTH  J drive to the bank
K  out  WIDTH  K drive to the bank
BUSY  out  1  high when state is not IDLE
DONE  out  1  one-cycle completion pulse
TC  out  1  one-cycle pulse on a wrap step (up from all-ones, down from zero)
ABORTED  out  1  set with DONE when a count ends by ABORT; cleared on the next accept
ERR  out  1  step-limit error flag (see Optional Feature)

Behaviour:
- Reset (RST_N low, asynchronous):
  - State = IDLE.
  - J, K, DONE, TC, ABORTED, ERR and the internal target register all cleared immediately.
  - CMD_READY = 1 and BUSY = 0 while in reset.
  - The bank has no reset; J=K=0 makes it hold its current value.
- States:
  - IDLE: J=K=0. On accept, go to APPLY (ops 0-3, 6, 7) or COUNT (ops 4, 5). CMD_DATA is captured.
  - APPLY: J/K hold the op pattern for exactly one cycle, then state goes to DONE.
    - CLEAR: J=0, K=all-ones.
    - PRESET: J=all-ones, K=0.
    - LOAD: J=data, K=~data.
    - TOGGLE: J=K=all-ones.
    - NOP/reserved: J=K=0.
  - COUNT: at each rising edge, compare Q_FB with the target.
    - Equal: J=K=0, go to DONE.
    - ABORT high (takes priority over the step): J=K=0, set ABORTED, go to DONE.
    - Otherwise apply J=K=step mask.
      - Up mask: bit i set when Q_FB[i-1:0] are all ones; bit 0 always set.
      - Down mask: bit i set when Q_FB[i-1:0] are all zeros; bit 0 always set.
    - Wrap-around is natural. TC pulses on the cycle the wrap mask is driven: up with Q_FB all-ones, or down with Q_FB zero.
  - DONE: J=K=0, DONE=1 for one cycle, then IDLE.
- Accept edge drives J=K=0. The first COUNT comparison happens on the following edge.
- Latency: single-shot ops show DONE 2 cycles after accept. A count of N steps shows DONE N+2 cycles after accept. A target equal to the current value gives zero steps and DONE 2 cycles after accept.
- CMD_VALID while BUSY is ignored; the command is not queued.
- Reset mid-operation: J/K drop to 0 asynchronously and the bank freezes at its current Q. No DONE pulse is generated.
- Equality is exact WIDTH-bit compare, unsigned.

Optional Feature:
JK_STEP_LIMIT_EN:
- Defined: adds a (WIDTH+1)-bit step counter, cleared on accept and incremented per applied step.
  - If 2**WIDTH steps are applied without a match, the block drives J=K=0, sets ERR, and goes to DONE.
  - ERR clears on the next accept.
- Undefined: no step counter; ERR is tied to 0 and COUNT runs until match or ABORT.

Test Plan:
1. Reset during a COUNT_UP from 0 to 15, at Q=5 -> J=K=0 within the reset-low window, Q holds 5, no DONE; after release CMD_READY=1 and BUSY=0.
2. LOAD 4'hA with Q=0 -> cycle after accept J=1010, K=0101; Q_FB=1010 at the next rising edge; DONE pulses; J/K return to 0.
3. COUNT_UP from Q=3 to target 7 -> masks 0111, 0001, 0011, 0001 on successive cycles; Q steps 4, 5, 6, 7; DONE 6 cycles after accept; TC stays 0.
4. COUNT_UP from Q=14 to target 1 -> Q steps 15, 0, 1; TC pulses once, on the 15->0 step; DONE after 3 steps.
5. COUNT_DOWN with Q=0 and target 0 -> no J/K activity; DONE 2 cycles after accept. A CMD_VALID LOAD issued while BUSY is ignored (Q unchanged).
6. COUNT_UP from 0 to 15 with ABORT asserted after 5 steps -> Q=5, J=K=0 on the next edge, DONE and ABORTED both 1. With JK_STEP_LIMIT_EN defined and Q_FB stuck at 0 -> ERR=1 and DONE after 16 steps.
